rfdc_nco_reset_sequencer: RTL and testbench
===========================================

// Module: rfdc_nco_reset_sequencer
//
// PURPOSE
//   Responder for the start_nco_reset / nco_reset_done handshake produced by the RFDC timing control.
//   On a start pulse it waits for a SYSREF-aligned boundary, then requests an NCO update on every
//   enabled RFDC tile, collects per-tile acks, and reports completion or timeout.
//   It sits between the timing-control CtrlPort logic and the RFDC tile NCO update interfaces, in the radio clock domain.
//
// PARAMETERS
//   NUM_TILES       4       Number of RFDC tiles sequenced (1..8)
//   SYSREF_ALIGN    1       1: wait for sysref_pulse before requesting; 0: request on the cycle after start
//   TIMEOUT_CYCLES  65535   Max cycles spent in WAIT_SYSREF or WAIT_ACK before abort (>=1)
//
// PORTS
//   clk              in   1          Radio/RFDC control clock
//   rst              in   1          Synchronous, active-high reset
//   start_nco_reset  in   1          Single-cycle start request
//   sysref_pulse     in   1          Single-cycle SYSREF edge marker, already in clk domain
//   tile_mask        in   NUM_TILES  1 = tile participates; sampled on an accepted start
//   tile_update_req  out  NUM_TILES  Level request to each tile's NCO update logic
//   tile_update_ack  in   NUM_TILES  Per-tile completion pulse or level
//   nco_reset_done   out  1          High when the last sequence has finished (success or timeout)
//   busy             out  1          High from an accepted start until done
//   timeout_err      out  1          Sticky: last sequence aborted on timeout
//
// BEHAVIOUR
// - Reset values: tile_update_req=0, nco_reset_done=0, busy=0, timeout_err=0, state=IDLE, counters=0.
// - FSM states: IDLE, WAIT_SYSREF, REQ_TILES, WAIT_ACK, FINISH.
// - IDLE: start_nco_reset=1 accepts the request.
//   - On accept: mask_r<=tile_mask, acked_r<=0, nco_reset_done<=0, timeout_err<=0, busy<=1.
//   - Next state is WAIT_SYSREF when SYSREF_ALIGN=1, otherwise REQ_TILES.
// - WAIT_SYSREF: sysref_pulse=1 -> REQ_TILES. A sysref_pulse in the same cycle as the accepted start is not used.
// - REQ_TILES (1 cycle): tile_update_req<=mask_r.
//   - mask_r==0: skip requests and go straight to FINISH.
//   - Otherwise go to WAIT_ACK.
// - WAIT_ACK:
//   - acked_r |= tile_update_ack & mask_r.
//   - tile_update_req bit drops the cycle after its own ack is seen.
//   - When (acked_r|new acks)==mask_r -> FINISH.
// - FINISH (1 cycle): tile_update_req<=0, nco_reset_done<=1, busy<=0, then IDLE.
// - Latency:
//   - start at cycle T, SYSREF_ALIGN=0: req high at T+2.
//   - SYSREF_ALIGN=1 with sysref at S>T: req high at S+2.
//   - Last ack at A: done=1 and busy=0 at A+2.
// - Timeout:
//   - Counter of width $clog2(TIMEOUT_CYCLES+1), cleared on every state entry.
//   - Increments each cycle in WAIT_SYSREF or WAIT_ACK.
//   - Reaching TIMEOUT_CYCLES -> timeout_err<=1, then FINISH (reqs drop, done asserts).
// - start_nco_reset while busy=1: ignored; no queueing, no state change.
// - Acks: ignored outside WAIT_ACK and on unmasked tiles. Acks held high after req drops cause no action.
// - tile_mask changes while busy have no effect until the next accepted start.
// - nco_reset_done stays 1 in IDLE until the next accepted start. timeout_err is sticky until the next accepted start.
// - rst mid-sequence: all outputs return to reset values on the next edge; no pending ack is remembered.
//
// TESTING
// 1. SYSREF_ALIGN=1, mask=4'b1111, start@10, sysref@20, all acks@25 -> req=4'hF @22..25, 0 @26; done=1 @27; busy 11..26.
// 2. mask=4'b0101, staggered acks: tile0@30, tile2@40, tile1 spurious@35 -> req[0] drops @31, req[2] drops @41; done @42; tile1 ack ignored.
// 3. TIMEOUT_CYCLES=16, mask=4'b0011, no ack on tile1 -> timeout_err=1 and done=1 exactly 16 cycles after WAIT_ACK entry; reqs=0.
// 4. SYSREF_ALIGN=1, no sysref, TIMEOUT_CYCLES=16 -> abort after 16 cycles in WAIT_SYSREF; tile_update_req never asserted.
// 5. Second start while busy, start in same cycle as sysref, mask=0 -> extra start ignored; same-cycle sysref unused; mask=0 gives done with no reqs.
// 6. rst asserted in WAIT_ACK with reqs high -> all outputs 0 next cycle; a fresh start then completes normally.

Source files
------------

// File: rtl/rfdc_nco_reset_sequencer.sv
// rfdc_nco_reset_sequencer: answers start_nco_reset by waiting for SYSREF, requesting per-tile NCO updates,
// collecting acks and reporting done or timeout.
module rfdc_nco_reset_sequencer #(
    parameter int NUM_TILES      = 4,
    parameter int SYSREF_ALIGN   = 1,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_nco_reset,
    input  logic                 sysref_pulse,
    input  logic [NUM_TILES-1:0] tile_mask,
    output logic [NUM_TILES-1:0] tile_update_req,
    input  logic [NUM_TILES-1:0] tile_update_ack,
    output logic                 nco_reset_done,
    output logic                 busy,
    output logic                 timeout_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, WAIT_SYSREF, REQ_TILES, WAIT_ACK, FINISH} state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [NUM_TILES-1:0] mask_r, mask_n, acked_r, acked_n, req_n, acks;
    logic                 done_n, busy_n, err_n, tmo, waiting;

    assign acks    = acked_r | (tile_update_ack & mask_r);
    assign waiting = (state == WAIT_SYSREF) || (state == WAIT_ACK);
    // The last allowed cycle in a wait state is the one where the counter shows TIMEOUT_CYCLES-1.
    assign tmo     = cnt == CW'(TIMEOUT_CYCLES - 1);

    always_comb begin
        state_n = state;
        mask_n  = mask_r;
        acked_n = acked_r;
        req_n   = tile_update_req;
        done_n  = nco_reset_done;
        busy_n  = busy;
        err_n   = timeout_err;
        unique case (state)
            IDLE: if (start_nco_reset) begin
                mask_n  = tile_mask;
                acked_n = '0;
                done_n  = 1'b0;
                err_n   = 1'b0;
                busy_n  = 1'b1;
                state_n = (SYSREF_ALIGN != 0) ? WAIT_SYSREF : REQ_TILES;
            end
            WAIT_SYSREF: begin
                state_n = sysref_pulse ? REQ_TILES : tmo ? FINISH : WAIT_SYSREF;
                err_n   = !sysref_pulse && tmo;
            end
            REQ_TILES: begin
                req_n   = mask_r;
                state_n = (mask_r == '0) ? FINISH : WAIT_ACK;
            end
            WAIT_ACK: begin
                acked_n = acks;
                req_n   = tile_update_req & ~(tile_update_ack & mask_r);
                state_n = (acks == mask_r) ? FINISH : tmo ? FINISH : WAIT_ACK;
                err_n   = (acks != mask_r) && tmo;
            end
            FINISH: begin
                req_n   = '0;
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        cnt_n = (state_n != state || !waiting) ? '0 : cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            mask_r          <= '0;
            acked_r         <= '0;
            tile_update_req <= '0;
            nco_reset_done  <= 1'b0;
            busy            <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            mask_r          <= mask_n;
            acked_r         <= acked_n;
            tile_update_req <= req_n;
            nco_reset_done  <= done_n;
            busy            <= busy_n;
            timeout_err     <= err_n;
        end
    end
endmodule

// File: tb/tb_rfdc_nco_reset_sequencer.sv
// tb_rfdc_nco_reset_sequencer: scoreboard bench; expected {req,done,busy,err} per cycle queued with stimulus.
module tb_rfdc_nco_reset_sequencer;
    logic       clk = 1'b0, rst = 1'b1, sysref = 1'b0;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [3:0] mask_a = '0, mask_b = '0, ack_a = '0, ack_b = '0;
    logic [3:0] req_a, req_b;
    logic       done_a, done_b, busy_a, busy_b, err_a, err_b;
    int         cyc = 0, tests = 0, fails = 0;

    typedef struct {
        int         d;
        int         c;
        string      t;
        logic [6:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    rfdc_nco_reset_sequencer #(.NUM_TILES(4), .SYSREF_ALIGN(1), .TIMEOUT_CYCLES(16)) dut_a (
        .clk(clk), .rst(rst), .start_nco_reset(start_a), .sysref_pulse(sysref), .tile_mask(mask_a),
        .tile_update_req(req_a), .tile_update_ack(ack_a), .nco_reset_done(done_a), .busy(busy_a),
        .timeout_err(err_a)
    );

    rfdc_nco_reset_sequencer #(.NUM_TILES(4), .SYSREF_ALIGN(0), .TIMEOUT_CYCLES(16)) dut_b (
        .clk(clk), .rst(rst), .start_nco_reset(start_b), .sysref_pulse(sysref), .tile_mask(mask_b),
        .tile_update_req(req_b), .tile_update_ack(ack_b), .nco_reset_done(done_b), .busy(busy_b),
        .timeout_err(err_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic void ex(input int d, input int c, input string t, input logic [3:0] r,
                               input logic dn, input logic b, input logic er);
        sb.push_back('{d, c, t, {r, dn, b, er}});
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk)
        while (sb.size() > 0 && sb[0].c <= cyc) begin
            e = sb.pop_front();
            check(e.t, 32'(e.d != 0 ? {req_b, done_b, busy_b, err_b} : {req_a, done_a, busy_a, err_a}), 32'(e.v));
        end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int b;
        tick(3);
        ex(0, cyc, "reset_a", 4'h0, 0, 0, 0);
        ex(1, cyc, "reset_b", 4'h0, 0, 0, 0);
        rst = 1'b0;
        tick(2);
        // all tiles, aligned to sysref; mask change and held acks must not matter
        b = cyc;
        ex(0, b+1, "s1_busy", 4'h0, 0, 1, 0);
        ex(0, b+11, "s1_reqtiles", 4'h0, 0, 1, 0);
        ex(0, b+12, "s1_req_on", 4'hF, 0, 1, 0);
        ex(0, b+15, "s1_req_hold", 4'hF, 0, 1, 0);
        ex(0, b+16, "s1_req_drop", 4'h0, 0, 1, 0);
        ex(0, b+17, "s1_done", 4'h0, 1, 0, 0);
        ex(0, b+19, "s1_idle", 4'h0, 1, 0, 0);
        mask_a = 4'hF; start_a = 1'b1; tick(1); start_a = 1'b0;
        tick(4); mask_a = 4'h0; tick(5);
        sysref = 1'b1; tick(1); sysref = 1'b0;
        tick(4); ack_a = 4'hF; tick(3); ack_a = 4'h0; tick(3);
        // staggered acks with a spurious ack on an unmasked tile
        b = cyc;
        ex(0, b, "s2_prior_done", 4'h0, 1, 0, 0);
        ex(0, b+1, "s2_start", 4'h0, 0, 1, 0);
        ex(0, b+4, "s2_req_on", 4'h5, 0, 1, 0);
        ex(0, b+5, "s2_req_t0", 4'h5, 0, 1, 0);
        ex(0, b+6, "s2_t0_drop", 4'h4, 0, 1, 0);
        ex(0, b+8, "s2_spurious", 4'h4, 0, 1, 0);
        ex(0, b+9, "s2_t2_wait", 4'h4, 0, 1, 0);
        ex(0, b+10, "s2_t2_drop", 4'h0, 0, 1, 0);
        ex(0, b+11, "s2_done", 4'h0, 1, 0, 0);
        mask_a = 4'h5; start_a = 1'b1; tick(1); start_a = 1'b0;
        tick(1); sysref = 1'b1; tick(1); sysref = 1'b0;
        tick(2); ack_a = 4'h1; tick(1); ack_a = 4'h0;
        tick(1); ack_a = 4'h2; tick(1); ack_a = 4'h0;
        tick(1); ack_a = 4'h4; tick(1); ack_a = 4'h0;
        tick(4);
        // tile1 never acks: abort after 16 cycles in WAIT_ACK (entered b+4)
        b = cyc;
        ex(0, b+4, "s3_req_on", 4'h3, 0, 1, 0);
        ex(0, b+6, "s3_t0_drop", 4'h2, 0, 1, 0);
        ex(0, b+19, "s3_last_wait", 4'h2, 0, 1, 0);
        ex(0, b+20, "s3_timeout", 4'h2, 0, 1, 1);
        ex(0, b+21, "s3_done", 4'h0, 1, 0, 1);
        ex(0, b+23, "s3_sticky", 4'h0, 1, 0, 1);
        mask_a = 4'h3; start_a = 1'b1; tick(1); start_a = 1'b0;
        tick(1); sysref = 1'b1; tick(1); sysref = 1'b0;
        tick(2); ack_a = 4'h1; tick(1); ack_a = 4'h0;
        tick(20);
        // no sysref: abort after 16 cycles in WAIT_SYSREF, no requests
        b = cyc;
        ex(0, b+1, "s4_err_clr", 4'h0, 0, 1, 0);
        ex(0, b+5, "s4_no_req", 4'h0, 0, 1, 0);
        ex(0, b+16, "s4_last_wait", 4'h0, 0, 1, 0);
        ex(0, b+17, "s4_timeout", 4'h0, 0, 1, 1);
        ex(0, b+18, "s4_done", 4'h0, 1, 0, 1);
        mask_a = 4'hF; start_a = 1'b1; tick(1); start_a = 1'b0;
        tick(20);
        // same-cycle sysref unused, start while busy ignored, empty mask finishes without requests
        b = cyc;
        ex(0, b+1, "s5_busy", 4'h0, 0, 1, 0);
        ex(0, b+3, "s5_restart_ign", 4'h0, 0, 1, 0);
        ex(0, b+5, "s5_reqtiles", 4'h0, 0, 1, 0);
        ex(0, b+6, "s5_finish", 4'h0, 0, 1, 0);
        ex(0, b+7, "s5_done", 4'h0, 1, 0, 0);
        ex(0, b+8, "s5_idle", 4'h0, 1, 0, 0);
        mask_a = 4'h0; start_a = 1'b1; sysref = 1'b1; tick(1); start_a = 1'b0; sysref = 1'b0;
        tick(1); mask_a = 4'hF; start_a = 1'b1; tick(1); start_a = 1'b0;
        tick(1); sysref = 1'b1; tick(1); sysref = 1'b0;
        tick(5);
        // reset while requests are high, then a fresh sequence
        b = cyc;
        ex(0, b+4, "s6_req_on", 4'hF, 0, 1, 0);
        ex(0, b+6, "s6_reset", 4'h0, 0, 0, 0);
        ex(0, b+8, "s6_restart", 4'h0, 0, 1, 0);
        ex(0, b+11, "s6_req_on2", 4'hF, 0, 1, 0);
        ex(0, b+12, "s6_req_hold2", 4'hF, 0, 1, 0);
        ex(0, b+13, "s6_req_drop2", 4'h0, 0, 1, 0);
        ex(0, b+14, "s6_done", 4'h0, 1, 0, 0);
        mask_a = 4'hF; start_a = 1'b1; tick(1); start_a = 1'b0;
        tick(1); sysref = 1'b1; tick(1); sysref = 1'b0;
        tick(2); rst = 1'b1; ack_a = 4'h1; tick(1); rst = 1'b0; ack_a = 4'h0;
        tick(1); start_a = 1'b1; tick(1); start_a = 1'b0;
        tick(1); sysref = 1'b1; tick(1); sysref = 1'b0;
        tick(2); ack_a = 4'hF; tick(1); ack_a = 4'h0;
        tick(4);
        // unaligned instance: request two cycles after start, sysref irrelevant
        b = cyc;
        ex(1, b+1, "b_busy", 4'h0, 0, 1, 0);
        ex(1, b+2, "b_req_on", 4'hA, 0, 1, 0);
        ex(1, b+4, "b_req_hold", 4'hA, 0, 1, 0);
        ex(1, b+5, "b_req_drop", 4'h0, 0, 1, 0);
        ex(1, b+6, "b_done", 4'h0, 1, 0, 0);
        mask_b = 4'hA; start_b = 1'b1; tick(1); start_b = 1'b0;
        sysref = 1'b1; tick(1); sysref = 1'b0;
        tick(2); ack_b = 4'hF; tick(1); ack_b = 4'h0;
        tick(4);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
